signed_window_stats: RTL and testbench

- Downstream consumer of the offset-binary-to-two's-complement converter on the ADC sample path.
- Accumulates a window of signed 8-bit samples and reports max, min, peak-to-peak and mean once per window.
- Feeds the amplitude / DC-offset measurement logic.
- Supports single-shot and continuous measurement modes.

---
 rtl/signed_window_stats.sv | 194 +++++++++++++++++++
 tb/tb_signed_window_stats.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_window_stats.sv
// -----------------------------------------------------------------------------
// signed_window_stats
//
// Collects a window of WINDOW signed 8-bit samples from the ADC sample path
// (after offset-binary to two's-complement conversion) and reports the
// maximum, minimum, peak-to-peak and floored mean of that window once it
// closes. A window can run as a single shot or restart continuously.
//
// Ports
//   clk           system clock, all state changes on its rising edge
//   rst_n         asynchronous active-low reset
//   sample_in     signed two's-complement sample
//   sample_en     sample_in is valid this cycle (ignored while idle)
//   start         one-cycle pulse, opens a window when idle
//   mode_cont     1 = reopen a fresh window as soon as one closes
//   clear         synchronous abort of the window in progress
//   busy          a window is in progress
//   result_valid  one-cycle pulse, result outputs were updated this cycle
//   max_out       signed maximum of the last completed window
//   min_out       signed minimum of the last completed window
//   vpp_out       unsigned max_out - min_out (0..255)
//   mean_out      signed floor(sum / WINDOW) of the last completed window
// -----------------------------------------------------------------------------
module signed_window_stats #(
  parameter int WINDOW      = 1024,
  parameter int LOG2_WINDOW = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample_in,
  input  logic       sample_en,
  input  logic       start,
  input  logic       mode_cont,
  input  logic       clear,
  output logic       busy,
  output logic       result_valid,
  output logic [7:0] max_out,
  output logic [7:0] min_out,
  output logic [8:0] vpp_out,
  output logic [7:0] mean_out
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ACCUM = 1'b1;

  // Sum of WINDOW 8-bit signed values needs LOG2_WINDOW extra bits.
  localparam int SUM_W = 8 + LOG2_WINDOW;

  localparam logic [LOG2_WINDOW-1:0] LAST_COUNT = LOG2_WINDOW'(WINDOW - 1);

  // Running extremes start at the opposite ends of the range so the first
  // accepted sample always replaces them.
  localparam logic signed [7:0] MAX_INIT = 8'sh80;
  localparam logic signed [7:0] MIN_INIT = 8'sh7F;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                    state_q,        state_d;
  logic [LOG2_WINDOW-1:0]  count_q,        count_d;
  logic signed [7:0]       run_max_q,      run_max_d;
  logic signed [7:0]       run_min_q,      run_min_d;
  logic signed [SUM_W-1:0] sum_q,          sum_d;
  logic                    result_valid_q, result_valid_d;
  logic [7:0]              max_out_q,      max_out_d;
  logic [7:0]              min_out_q,      min_out_d;
  logic [8:0]              vpp_out_q,      vpp_out_d;
  logic [7:0]              mean_out_q,     mean_out_d;

  // ---------------------------------------------------------------------------
  // Accumulator update including the sample offered this cycle. The closing
  // sample must be part of the result, so the result path uses these values
  // rather than the registered ones.
  // ---------------------------------------------------------------------------
  logic signed [7:0]       sample_s;
  logic signed [SUM_W-1:0] sample_ext;
  logic signed [7:0]       acc_max;
  logic signed [7:0]       acc_min;
  logic signed [SUM_W-1:0] acc_sum;
  logic                    accept;
  logic                    closing;

  assign sample_s   = sample_in;
  assign sample_ext = {{LOG2_WINDOW{sample_in[7]}}, sample_in};
  assign acc_max    = (sample_s > run_max_q) ? sample_s : run_max_q;
  assign acc_min    = (sample_s < run_min_q) ? sample_s : run_min_q;
  assign acc_sum    = sum_q + sample_ext;
  assign accept     = (state_q == ST_ACCUM) && sample_en;
  assign closing    = accept && (count_q == LAST_COUNT);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    run_max_d      = run_max_q;
    run_min_d      = run_min_q;
    sum_d          = sum_q;
    result_valid_d = 1'b0;
    max_out_d      = max_out_q;
    min_out_d      = min_out_q;
    vpp_out_d      = vpp_out_q;
    mean_out_d     = mean_out_q;

    if (clear) begin
      // Abort wins over start and over a closing sample; the partial window
      // is dropped and the previous results stay visible.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_ACCUM;
            count_d   = '0;
            run_max_d = MAX_INIT;
            run_min_d = MIN_INIT;
            sum_d     = '0;
          end
        end

        ST_ACCUM: begin
          if (closing) begin
            result_valid_d = 1'b1;
            max_out_d      = acc_max;
            min_out_d      = acc_min;
            // max >= min always holds, so the 9-bit difference is 0..255.
            vpp_out_d      = {acc_max[7], acc_max} - {acc_min[7], acc_min};
            // Arithmetic shift right by LOG2_WINDOW floors toward -inf; the
            // 8 bits above the shift are the complete in-range quotient.
            mean_out_d     = acc_sum[LOG2_WINDOW +: 8];

            // Fresh accumulators on the closing edge so a sample in the very
            // next cycle already counts towards the following window.
            count_d   = '0;
            run_max_d = MAX_INIT;
            run_min_d = MIN_INIT;
            sum_d     = '0;
            state_d   = mode_cont ? ST_ACCUM : ST_IDLE;
          end else if (accept) begin
            count_d   = count_q + LOG2_WINDOW'(1);
            run_max_d = acc_max;
            run_min_d = acc_min;
            sum_d     = acc_sum;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      run_max_q      <= MAX_INIT;
      run_min_q      <= MIN_INIT;
      sum_q          <= '0;
      result_valid_q <= 1'b0;
      max_out_q      <= '0;
      min_out_q      <= '0;
      vpp_out_q      <= '0;
      mean_out_q     <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      run_max_q      <= run_max_d;
      run_min_q      <= run_min_d;
      sum_q          <= sum_d;
      result_valid_q <= result_valid_d;
      max_out_q      <= max_out_d;
      min_out_q      <= min_out_d;
      vpp_out_q      <= vpp_out_d;
      mean_out_q     <= mean_out_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy         = (state_q == ST_ACCUM);
  assign result_valid = result_valid_q;
  assign max_out      = max_out_q;
  assign min_out      = min_out_q;
  assign vpp_out      = vpp_out_q;
  assign mean_out     = mean_out_q;

endmodule

// File: tb/tb_signed_window_stats.sv
// -----------------------------------------------------------------------------
// tb_signed_window_stats
//
// Directed bench for signed_window_stats with an 8-sample window. Each
// scenario task drives its stimulus and compares outputs against
// hand-computed values, sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_signed_window_stats;

  logic       clk;
  logic       rst_n;
  logic [7:0] sample_in;
  logic       sample_en;
  logic       start;
  logic       mode_cont;
  logic       clear;
  logic       busy;
  logic       result_valid;
  logic [7:0] max_out;
  logic [7:0] min_out;
  logic [8:0] vpp_out;
  logic [7:0] mean_out;

  int total;
  int bad;

  signed_window_stats #(
    .WINDOW      (8),
    .LOG2_WINDOW (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_en    (sample_en),
    .start        (start),
    .mode_cont    (mode_cont),
    .clear        (clear),
    .busy         (busy),
    .result_valid (result_valid),
    .max_out      (max_out),
    .min_out      (min_out),
    .vpp_out      (vpp_out),
    .mean_out     (mean_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample_in = 8'($urandom);
      sample_en = 1'($urandom);
      start     = 1'($urandom);
      mode_cont = 1'($urandom);
      clear     = 1'($urandom);
      tick();
      total++;
      if ({busy, result_valid, max_out, min_out, vpp_out, mean_out} !== 35'd0) begin
        bad++;
        $display("FAIL reset_outputs cycle %0d: got busy=%b rv=%b max=%h min=%h vpp=%h mean=%h, want all 0",
                 i, busy, result_valid, max_out, min_out, vpp_out, mean_out);
      end
    end
    sample_en = 1'b0; start = 1'b0; mode_cont = 1'b0; clear = 1'b0; sample_in = 8'd0;
    rst_n = 1'b1;
    tick();
    // sample_en without start is ignored while idle
    for (int i = 0; i < 10; i++) begin
      sample_en = 1'b1;
      sample_in = 8'($urandom);
      tick();
      total++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_ignore cycle %0d: got rv=%b busy=%b, want rv=0 busy=0", i, result_valid, busy);
      end
    end
    sample_en = 1'b0;
    tick();
    $display("test_reset complete");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_extremes();
    logic [7:0] vec [8];
    vec = '{8'h80, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_start();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL extremes_busy_after_start: got %b want 1", busy);
    end
    for (int i = 0; i < 8; i++) begin
      sample_en = 1'b1;
      sample_in = vec[i];
      tick();
      if (i < 7) begin
        total++;
        if (result_valid !== 1'b0) begin
          bad++;
          $display("FAIL extremes_early_rv sample %0d: got %b want 0", i, result_valid);
        end
      end
    end
    sample_en = 1'b0;
    total++;
    if (result_valid !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL extremes_close: got rv=%b busy=%b want rv=1 busy=0", result_valid, busy);
    end
    total++;
    if (max_out !== 8'h7F || min_out !== 8'h80 || vpp_out !== 9'd255 || mean_out !== 8'hFF) begin
      bad++;
      $display("FAIL extremes_results: got max=%h min=%h vpp=%0d mean=%h want 7f 80 255 ff",
               max_out, min_out, vpp_out, mean_out);
    end
    $display("window extremes: max=%h min=%h vpp=%0d mean=%h", max_out, min_out, vpp_out, mean_out);
    tick();
    total++;
    if (result_valid !== 1'b0) begin
      bad++;
      $display("FAIL extremes_rv_one_cycle: got %b want 0", result_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_clear();
    do_start();
    for (int i = 0; i < 4; i++) begin
      sample_en = 1'b1;
      sample_in = 8'd50;
      tick();
    end
    sample_en = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      bad++;
      $display("FAIL clear_abort: got busy=%b rv=%b want 0 0", busy, result_valid);
    end
    total++;
    if (max_out !== 8'h7F || min_out !== 8'h80 || vpp_out !== 9'd255 || mean_out !== 8'hFF) begin
      bad++;
      $display("FAIL clear_hold: got max=%h min=%h vpp=%0d mean=%h want 7f 80 255 ff",
               max_out, min_out, vpp_out, mean_out);
    end
    // clear arriving with the closing sample wins over the close
    do_start();
    for (int i = 0; i < 8; i++) begin
      sample_en = 1'b1;
      sample_in = 8'd20;
      clear     = (i == 7);
      tick();
    end
    sample_en = 1'b0; clear = 1'b0;
    total++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || mean_out !== 8'hFF) begin
      bad++;
      $display("FAIL clear_beats_close: got rv=%b busy=%b mean=%h want 0 0 ff", result_valid, busy, mean_out);
    end
    // a fresh window runs normally afterwards
    do_start();
    for (int i = 0; i < 8; i++) begin
      sample_en = 1'b1;
      sample_in = 8'd1;
      tick();
    end
    sample_en = 1'b0;
    total++;
    if (result_valid !== 1'b1 || mean_out !== 8'd1 || max_out !== 8'd1 || min_out !== 8'd1 || vpp_out !== 9'd0) begin
      bad++;
      $display("FAIL clear_restart: got rv=%b max=%h min=%h vpp=%0d mean=%h want 1 01 01 0 01",
               result_valid, max_out, min_out, vpp_out, mean_out);
    end
    $display("window after clear: mean=%h", mean_out);
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_sparse();
    int pulses;
    int enabled;
    pulses  = 0;
    enabled = 0;
    do_start();
    for (int i = 0; i < 18; i++) begin
      sample_en = (i % 2 == 0);
      sample_in = (i % 2 == 0) ? 8'd5 : 8'($urandom);
      // start while accumulating (including on the closing sample) is ignored
      start     = (i == 14);
      if (sample_en) enabled++;
      tick();
      if (result_valid) pulses++;
      total++;
      if (result_valid !== (enabled == 8 && i == 14)) begin
        bad++;
        $display("FAIL sparse_rv_timing cycle %0d: got %b want %b", i, result_valid, (enabled == 8 && i == 14));
      end
      if (i == 14) begin
        total++;
        if (max_out !== 8'd5 || min_out !== 8'd5 || vpp_out !== 9'd0 || mean_out !== 8'd5 || busy !== 1'b0) begin
          bad++;
          $display("FAIL sparse_results: got max=%h min=%h vpp=%0d mean=%h busy=%b want 05 05 0 05 0",
                   max_out, min_out, vpp_out, mean_out, busy);
        end
        $display("window sparse: mean=%h", mean_out);
      end
    end
    sample_en = 1'b0; start = 1'b0;
    total++;
    if (pulses != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL sparse_pulse_count: got pulses=%0d busy=%b want 1 0", pulses, busy);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    mode_cont = 1'b1;
    do_start();
    for (int i = 0; i < 16; i++) begin
      sample_en = 1'b1;
      sample_in = (i < 8) ? 8'd10 : 8'hEC;
      tick();
      total++;
      if (busy !== 1'b1 || result_valid !== (i == 7 || i == 15)) begin
        bad++;
        $display("FAIL cont_timing cycle %0d: got busy=%b rv=%b want 1 %b", i, busy, result_valid, (i == 7 || i == 15));
      end
      if (i == 7) begin
        total++;
        if (mean_out !== 8'd10 || vpp_out !== 9'd0 || max_out !== 8'd10) begin
          bad++;
          $display("FAIL cont_window1: got mean=%h vpp=%0d max=%h want 0a 0 0a", mean_out, vpp_out, max_out);
        end
        $display("window cont 1: mean=%h", mean_out);
      end
      if (i == 15) begin
        total++;
        if (mean_out !== 8'hEC || vpp_out !== 9'd0 || min_out !== 8'hEC) begin
          bad++;
          $display("FAIL cont_window2: got mean=%h vpp=%0d min=%h want ec 0 ec", mean_out, vpp_out, min_out);
        end
        $display("window cont 2: mean=%h", mean_out);
      end
    end
    sample_en = 1'b0;
    mode_cont = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL cont_stop: got busy=%b want 0", busy);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_async_reset();
    logic [7:0] vec [8];
    vec = '{8'h03, 8'hFF, 8'h02, 8'hFB, 8'h00, 8'h07, 8'hF8, 8'h01};
    do_start();
    for (int i = 0; i < 5; i++) begin
      sample_en = 1'b1;
      sample_in = 8'd9;
      tick();
    end
    sample_en = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, result_valid, max_out, min_out, vpp_out, mean_out} !== 35'd0) begin
      bad++;
      $display("FAIL async_reset: got busy=%b rv=%b max=%h min=%h vpp=%h mean=%h want all 0",
               busy, result_valid, max_out, min_out, vpp_out, mean_out);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample_en = 1'b1;
      tick();
      total++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL async_no_pulse cycle %0d: got rv=%b busy=%b want 0 0", i, result_valid, busy);
      end
    end
    sample_en = 1'b0;
    do_start();
    for (int i = 0; i < 8; i++) begin
      sample_en = 1'b1;
      sample_in = vec[i];
      tick();
    end
    sample_en = 1'b0;
    // sum = -1 -> mean floors to -1; max 7, min -8
    total++;
    if (result_valid !== 1'b1 || max_out !== 8'h07 || min_out !== 8'hF8 || vpp_out !== 9'd15 || mean_out !== 8'hFF) begin
      bad++;
      $display("FAIL async_restart: got rv=%b max=%h min=%h vpp=%0d mean=%h want 1 07 f8 15 ff",
               result_valid, max_out, min_out, vpp_out, mean_out);
    end
    $display("window after reset: max=%h min=%h vpp=%0d mean=%h", max_out, min_out, vpp_out, mean_out);
    tick();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    sample_in = 8'd0;
    sample_en = 1'b0;
    start     = 1'b0;
    mode_cont = 1'b0;
    clear     = 1'b0;
    test_reset();
    test_extremes();
    test_clear();
    test_sparse();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
